// File: rtl/jk_cmd_seq_pkg.sv
// Shared definitions for the JK command sequencer: opcode encoding and
// command-word width helper used by the top level and the command FIFO.
package jk_cmd_seq_pkg;

    // Two-bit command opcode carried alongside the per-bit mask.
    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    localparam int OP_W = 2;

    // Stored command word is {op, mask}.
    function automatic int cmd_w(input int width);
        return width + OP_W;
    endfunction

endpackage

// File: rtl/jk_cmd_seq_fifo.sv
// Synchronous command FIFO: DEPTH entries (power of two) of W bits,
// combinational read of the head entry, registered occupancy count.
import jk_cmd_seq_pkg::*;

module jk_cmd_seq_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: buffers set/clear/toggle/hold commands and issues
// at most one per clock as registered one-cycle J/K/En pulses.
// Optional shadow of downstream Q enabled by defining JK_CMD_SHADOW_EN;
// otherwise q_shadow is tied to zero.
import jk_cmd_seq_pkg::*;

module jk_cmd_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [WIDTH-1:0]        cmd_mask,
    input  logic                    stall,
    output logic [WIDTH-1:0]        j,
    output logic [WIDTH-1:0]        k,
    output logic [WIDTH-1:0]        en,
    output logic [$clog2(DEPTH):0]  count,
    output logic [WIDTH-1:0]        q_shadow
);

    localparam int CW = cmd_w(WIDTH);

    logic [CW-1:0]    wdata;
    logic [CW-1:0]    rdata;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    jk_op_e           head_op;
    logic [WIDTH-1:0] head_mask;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic [WIDTH-1:0] en_nxt;

    // Ready comes only from registered occupancy: no pass-through when full.
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign pop       = ~empty & ~stall;
    assign wdata     = {cmd_op, cmd_mask};
    assign head_op   = jk_op_e'(rdata[CW-1 -: OP_W]);
    assign head_mask = rdata[WIDTH-1:0];

    jk_cmd_seq_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Decode head entry; no pop (empty/stall) or HOLD yields an all-zero slot.
    always_comb begin
        j_nxt  = '0;
        k_nxt  = '0;
        en_nxt = '0;
        if (pop) begin
            case (head_op)
                OP_SET: begin
                    j_nxt  = head_mask;
                    en_nxt = head_mask;
                end
                OP_CLEAR: begin
                    k_nxt  = head_mask;
                    en_nxt = head_mask;
                end
                OP_TOGGLE: begin
                    j_nxt  = head_mask;
                    k_nxt  = head_mask;
                    en_nxt = head_mask;
                end
                default: ;
            endcase
        end
    end

    // Output registers reload every edge, so en never persists past one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j  <= '0;
            k  <= '0;
            en <= '0;
        end else begin
            j  <= j_nxt;
            k  <= k_nxt;
            en <= en_nxt;
        end
    end

`ifdef JK_CMD_SHADOW_EN
    // Mirror the downstream JK bank: Q+ = J&~Q | ~K&Q on enabled bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_shadow <= '0;
        else       q_shadow <= (en & ((j & ~q_shadow) | (~k & q_shadow)))
                             | (~en & q_shadow);
    end
`else
    assign q_shadow = '0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq: directed scenario tasks plus a
// scoreboard of expected {j,k,en} pulses queued on acceptance.
module tb_jk_cmd_seq;

    localparam int W = 8;
    localparam int D = 4;
`ifdef JK_CMD_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [W-1:0]     cmd_mask;
    logic             stall;
    logic [W-1:0]     j;
    logic [W-1:0]     k;
    logic [W-1:0]     en;
    logic [$clog2(D):0] count;
    logic [W-1:0]     q_shadow;

    int errors = 0;
    int checks = 0;
    logic [3*W-1:0] exp_q [$];

    jk_cmd_seq #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .stall(stall),
        .j(j), .k(k), .en(en), .count(count), .q_shadow(q_shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] shx(input logic [W-1:0] v);
        return SHADOW ? v : '0;
    endfunction

    // Scoreboard producer: accepted non-HOLD commands queue their pulse.
    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            case (cmd_op)
                2'b10: exp_q.push_back({cmd_mask, {W{1'b0}}, cmd_mask});
                2'b01: exp_q.push_back({{W{1'b0}}, cmd_mask, cmd_mask});
                2'b11: exp_q.push_back({cmd_mask, cmd_mask, cmd_mask});
                default: ;
            endcase
        end
    end

    // Scoreboard consumer: every nonzero en pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset && en != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got j=%h k=%h en=%h, expected no issue", j, k, en);
            end else begin
                logic [3*W-1:0] e;
                e = exp_q.pop_front();
                if ({j, k, en} !== e) begin
                    errors++;
                    $display("FAIL sb_order: got j/k/en=%h, expected %h", {j, k, en}, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = '0;
        #3;
        checks++;
        if ({j, k, en} !== '0 || count !== '0 || cmd_ready !== 1'b1 || q_shadow !== '0) begin
            errors++;
            $display("FAIL reset_state: j=%h k=%h en=%h count=%0d rdy=%b q=%h, expected all 0, rdy=1",
                     j, k, en, count, cmd_ready, q_shadow);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_set();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 8'h0F;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (en !== '0) begin
            errors++;
            $display("FAIL set_no_early_issue: en=%h, expected 00", en);
        end
        @(negedge clk);
        checks++;
        if (j !== 8'h0F || k !== 8'h00 || en !== 8'h0F) begin
            errors++;
            $display("FAIL set_pulse: j=%h k=%h en=%h, expected 0f 00 0f", j, k, en);
        end
        @(negedge clk);
        checks++;
        if (en !== '0 || q_shadow !== shx(8'h0F)) begin
            errors++;
            $display("FAIL set_after: en=%h q=%h, expected en=00 q=%h", en, q_shadow, shx(8'h0F));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_toggle();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_mask = 8'hFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (j !== 8'hFF || k !== 8'hFF || en !== 8'hFF) begin
            errors++;
            $display("FAIL toggle_pulse: j=%h k=%h en=%h, expected ff ff ff", j, k, en);
        end
        @(negedge clk);
        checks++;
        if (en !== '0 || q_shadow !== shx(8'hF0)) begin
            errors++;
            $display("FAIL toggle_after: en=%h q=%h, expected en=00 q=%h", en, q_shadow, shx(8'hF0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        logic [1:0]   ops   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [W-1:0] masks [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op = ops[i]; cmd_mask = masks[i];
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || cmd_ready !== 1'b0 || en !== '0) begin
            errors++;
            $display("FAIL fill_full: count=%0d rdy=%b en=%h, expected 4 0 00", count, cmd_ready, en);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 8'h80;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fill_reject5: count=%0d, expected 4", count);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (en !== masks[i]) begin
                errors++;
                $display("FAIL fill_drain_%0d: en=%h, expected %h", i, en, masks[i]);
            end
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL fill_empty: count=%0d, expected 0", count);
        end
        @(negedge clk);
        checks++;
        if (q_shadow !== shx(8'hFD) || en !== '0) begin
            errors++;
            $display("FAIL fill_shadow: q=%h en=%h, expected q=%h en=00", q_shadow, en, shx(8'hFD));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold_gap();
        logic [1:0]   ops   [3] = '{2'b10, 2'b00, 2'b01};
        logic [W-1:0] seen  [5];
        logic [W-1:0] want  [5] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i < 3); cmd_op = (i < 3) ? ops[i] : 2'b00; cmd_mask = 8'h01;
            @(negedge clk);
            seen[i] = en;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
                errors++;
                $display("FAIL hold_gap_%0d: en=%h, expected %h", i, seen[i], want[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (q_shadow !== shx(8'hFC)) begin
            errors++;
            $display("FAIL hold_shadow: q=%h, expected %h", q_shadow, shx(8'hFC));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 8'(1 << i);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        for (int i = 0; i < 3 * D; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'(1 + (i % 3));
            cmd_mask  = 8'(1 << ((i + 2) % W)) | 8'h80;
            @(negedge clk);
            checks++;
            if (count !== 3'd2 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_count_%0d: count=%0d rdy=%b, expected 2 1", i, count, cmd_ready);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL b2b_drain: count=%0d, expected 0", count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 8'(8'h11 << i);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== 8'h11 || count !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_pre: en=%h count=%0d, expected 11 3", en, count);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({j, k, en} !== '0 || count !== '0 || cmd_ready !== 1'b1 || q_shadow !== '0) begin
            errors++;
            $display("FAIL rstmid_async: j=%h k=%h en=%h count=%0d rdy=%b q=%h, expected 0s rdy=1",
                     j, k, en, count, cmd_ready, q_shadow);
        end
        exp_q.delete();
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (en !== '0 || count !== '0) begin
                errors++;
                $display("FAIL rstmid_stale_%0d: en=%h count=%0d, expected 00 0", i, en, count);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle();
        test_fill();
        test_hold_gap();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d pulses never issued, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
